dc_motor_ramp_ctrl: RTL and testbench
=====================================

DC_MOTOR_RAMP_CTRL -- requirements
Module: dc_motor_ramp_ctrl

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, clock frequency in Hz.
REQ-002 Parameter STEP_MS, default 50, milliseconds per one-level ramp step.
REQ-003 Parameter DEADTIME_MS, default 100, zero-speed dwell in ms before a direction change.
REQ-004 Parameter MAX_LEVEL, default 15, highest speed_level driven (1..15).
REQ-005 Port clk, in, 1, single system clock; all logic is on its rising edge.
REQ-006 Port rst, in, 1, asynchronous active-high reset.
REQ-007 Port enable, in, 1, run request; low commands a ramp to zero.
REQ-008 Port target_level, in, 4, requested speed level.
REQ-009 Port target_dir, in, 1, requested rotation direction.
REQ-010 Port estop, in, 1, emergency stop, level sensitive.
REQ-011 Port speed_level, out, 4, level fed to the PWM generator's speed_level input.
REQ-012 Port motor_dir, out, 1, direction line to the H-bridge.
REQ-013 Port busy, out, 1, high in ACCEL, DECEL or DEADTIME.
REQ-014 Port at_target, out, 1, high when output equals effective request.

Function
REQ-015 STEP_CYCLES = CLK_FREQ/1000*STEP_MS; DEAD_CYCLES = CLK_FREQ/1000*DEADTIME_MS; both are integer, computed at elaboration, and at least 1.
REQ-016 eff_target = 0 when enable is low, else min(target_level, MAX_LEVEL).
REQ-017 States: IDLE, ACCEL, DECEL, HOLD, DEADTIME, ESTOP.
REQ-018 IDLE/HOLD: speed_level constant; go to ACCEL if eff_target>speed_level and dir matches; go to DECEL if eff_target<speed_level, or if target_dir!=motor_dir with speed_level>0.
REQ-019 Step counter clears on entry to ACCEL/DECEL from IDLE/HOLD; first step occurs STEP_CYCLES cycles after that entry, then every STEP_CYCLES cycles.
REQ-020 ACCEL: +1 per step; on reaching eff_target go to HOLD; if eff_target drops below speed_level, switch to DECEL with no counter clear.
REQ-021 DECEL: -1 per step; stop at eff_target (HOLD) or, on a pending direction change, at 0 (DEADTIME); switch to ACCEL with no counter clear if eff_target rises above speed_level with no pending direction change.
REQ-022 speed_level never exceeds MAX_LEVEL and never wraps below 0.
REQ-023 Direction change at speed_level==0 (IDLE) enters DEADTIME directly.
REQ-024 DEADTIME: speed_level=0 for DEAD_CYCLES cycles; motor_dir<=target_dir on exit; then ACCEL if eff_target>0, else IDLE.
REQ-025 HOLD with eff_target==0 and speed_level==0 returns to IDLE.
REQ-026 estop high in any state: next edge speed_level=0, state ESTOP, motor_dir unchanged; estop has priority over all other events.
REQ-027 ESTOP exits to IDLE only when estop low AND enable low in the same cycle.
REQ-028 at_target = (state IDLE or HOLD) AND speed_level==eff_target AND (motor_dir==target_dir OR speed_level==0); low in ESTOP.
REQ-029 All outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-030 rst high: state IDLE, speed_level=0, motor_dir=0, busy=0, at_target=0, counters 0, immediately and independent of clk.
REQ-031 After rst deasserts, the first state evaluation occurs on the next rising edge of clk.

Configuration
REQ-032 Macro DC_RAMP_DEADTIME_EN defined: DEADTIME state and DEAD_CYCLES counter are present per REQ-024.
REQ-033 Macro absent: no DEADTIME state; on speed 0 with a pending direction change, motor_dir<=target_dir on that edge and ACCEL/IDLE follows directly.

Verification (CLK_FREQ=1000, STEP_MS=2, DEADTIME_MS=4, MAX_LEVEL=15, macro defined)
REQ-034 enable=1, target=3, dir=0 from IDLE: speed_level 1,2,3 at cycles 2,4,6 after the request; busy falls and at_target rises with level 3.
REQ-035 Ramping toward 15, target changed to 5 at level 8: DECEL to 5, then HOLD, with no overshoot.
REQ-036 HOLD at 2 with target_dir toggled: level 1,0 at +2,+4 cycles; motor_dir flips 4 cycles later; then ramps to 2.
REQ-037 estop at level 5: speed_level=0 next cycle; estop low with enable=1 stays ESTOP; enable=0 gives IDLE next cycle.
REQ-038 rst pulsed mid-ACCEL between clk edges: speed_level=0 and motor_dir=0 before the next edge.
REQ-039 MAX_LEVEL=10, target=15: ramps to 10 and HOLDs with at_target=1; repeat REQ-036 with the macro undefined: motor_dir flips on the cycle level reaches 0.

Source files
------------

// File: rtl/dc_motor_ramp_ctrl.sv
// Speed-level ramp controller for a PWM-driven DC motor with direction reversal and emergency stop.
// Define DC_RAMP_DEADTIME_EN to add the zero-speed DEADTIME dwell before each direction change.
module dc_motor_ramp_ctrl #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int STEP_MS     = 50,
  parameter int DEADTIME_MS = 100,
  parameter int MAX_LEVEL   = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] target_level,
  input  logic       target_dir,
  input  logic       estop,
  output logic [3:0] speed_level,
  output logic       motor_dir,
  output logic       busy,
  output logic       at_target
);

  localparam int          STEP_RAW    = CLK_FREQ / 1000 * STEP_MS;
  localparam int          STEP_CYCLES = (STEP_RAW < 1) ? 1 : STEP_RAW;
  localparam logic [31:0] STEP_LAST   = 32'(STEP_CYCLES - 1);
  localparam logic [3:0]  MAX_LV      = 4'(MAX_LEVEL);
`ifdef DC_RAMP_DEADTIME_EN
  localparam int          DEAD_RAW    = CLK_FREQ / 1000 * DEADTIME_MS;
  localparam int          DEAD_CYCLES = (DEAD_RAW < 1) ? 1 : DEAD_RAW;
  localparam logic [31:0] DEAD_LAST   = 32'(DEAD_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    ACCEL,
    DECEL,
    HOLD,
`ifdef DC_RAMP_DEADTIME_EN
    DEADTIME,
`endif
    ESTOP
  } state_t;

  state_t      state, state_next;
  logic [3:0]  level_next;
  logic        dir_next, busy_next, at_next;
  logic [31:0] step_cnt, step_cnt_next, step_adv;
  logic [3:0]  eff_target;
  logic        dir_change, step_due, zero_reverse;
`ifdef DC_RAMP_DEADTIME_EN
  logic [31:0] dead_cnt, dead_cnt_next;
`endif

  assign eff_target = !enable ? 4'd0 : ((target_level > MAX_LV) ? MAX_LV : target_level);
  assign dir_change = (target_dir != motor_dir);
  assign step_due   = (step_cnt == STEP_LAST);
  assign step_adv   = step_due ? 32'd0 : step_cnt + 32'd1;

  always_comb begin
    state_next    = state;
    level_next    = speed_level;
    dir_next      = motor_dir;
    step_cnt_next = step_cnt;
    zero_reverse  = 1'b0;
`ifdef DC_RAMP_DEADTIME_EN
    dead_cnt_next = dead_cnt;
`endif
    if (estop) begin
      state_next    = ESTOP;
      level_next    = 4'd0;
      step_cnt_next = 32'd0;
`ifdef DC_RAMP_DEADTIME_EN
      dead_cnt_next = 32'd0;
`endif
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (dir_change && speed_level == 4'd0) begin
            zero_reverse = 1'b1;
          end else if (dir_change || eff_target < speed_level) begin
            state_next    = DECEL;
            step_cnt_next = 32'd0;
          end else if (eff_target > speed_level) begin
            state_next    = ACCEL;
            step_cnt_next = 32'd0;
          end else if (speed_level == 4'd0) begin
            state_next = IDLE;
          end
        end
        ACCEL: begin
          // Reversing the ramp keeps the step phase running so no partial step is lost.
          if (dir_change || eff_target < speed_level) begin
            state_next    = DECEL;
            step_cnt_next = step_adv;
          end else if (eff_target == speed_level) begin
            state_next    = HOLD;
            step_cnt_next = 32'd0;
          end else begin
            step_cnt_next = step_adv;
            if (step_due) begin
              level_next = speed_level + 4'd1;
              if (speed_level + 4'd1 == eff_target) state_next = HOLD;
            end
          end
        end
        DECEL: begin
          if (dir_change && speed_level == 4'd0) begin
            zero_reverse = 1'b1;
          end else if (!dir_change && eff_target > speed_level) begin
            state_next    = ACCEL;
            step_cnt_next = step_adv;
          end else if (!dir_change && eff_target == speed_level) begin
            state_next    = HOLD;
            step_cnt_next = 32'd0;
          end else begin
            // Here speed_level is nonzero: either a reversal is pending or the target is below.
            step_cnt_next = step_adv;
            if (step_due) begin
              level_next = speed_level - 4'd1;
              if (dir_change && speed_level == 4'd1) begin
                zero_reverse = 1'b1;
              end else if (!dir_change && speed_level - 4'd1 == eff_target) begin
                state_next = HOLD;
              end
            end
          end
        end
`ifdef DC_RAMP_DEADTIME_EN
        DEADTIME: begin
          level_next    = 4'd0;
          dead_cnt_next = dead_cnt + 32'd1;
          if (dead_cnt == DEAD_LAST) begin
            dir_next      = target_dir;
            state_next    = (eff_target > 4'd0) ? ACCEL : IDLE;
            step_cnt_next = 32'd0;
            dead_cnt_next = 32'd0;
          end
        end
`endif
        ESTOP: begin
          level_next = 4'd0;
          if (!enable) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end

    if (zero_reverse) begin
`ifdef DC_RAMP_DEADTIME_EN
      state_next    = DEADTIME;
      dead_cnt_next = 32'd0;
`else
      dir_next      = target_dir;
      state_next    = (eff_target > 4'd0) ? ACCEL : IDLE;
      step_cnt_next = 32'd0;
`endif
    end

    busy_next = (state_next == ACCEL) || (state_next == DECEL);
`ifdef DC_RAMP_DEADTIME_EN
    if (state_next == DEADTIME) busy_next = 1'b1;
`endif
    at_next = ((state_next == IDLE) || (state_next == HOLD)) && (level_next == eff_target) &&
              ((dir_next == target_dir) || (level_next == 4'd0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      speed_level <= 4'd0;
      motor_dir   <= 1'b0;
      busy        <= 1'b0;
      at_target   <= 1'b0;
      step_cnt    <= 32'd0;
`ifdef DC_RAMP_DEADTIME_EN
      dead_cnt    <= 32'd0;
`endif
    end else begin
      state       <= state_next;
      speed_level <= level_next;
      motor_dir   <= dir_next;
      busy        <= busy_next;
      at_target   <= at_next;
      step_cnt    <= step_cnt_next;
`ifdef DC_RAMP_DEADTIME_EN
      dead_cnt    <= dead_cnt_next;
`endif
    end
  end

endmodule

// File: tb/tb_dc_motor_ramp_ctrl.sv
// Bench for dc_motor_ramp_ctrl: two instances (MAX_LEVEL 15 and 10) checked every cycle
// against a countdown-timer model, plus hand-computed waypoints for the directed scenarios.
module tb_dc_motor_ramp_ctrl;

  localparam int STEP_N = 2;
  localparam int DEAD_N = 4;
`ifdef DC_RAMP_DEADTIME_EN
  localparam bit DEAD_EN = 1'b1;
`else
  localparam bit DEAD_EN = 1'b0;
`endif
  localparam int P_IDLE = 0, P_ACCEL = 1, P_DECEL = 2, P_HOLD = 3, P_DEAD = 4, P_ESTOP = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] target_level = 4'd0;
  logic       target_dir = 1'b0;
  logic       estop = 1'b0;
  logic [3:0] speed0, speed1;
  logic       dir0, dir1, busy0, busy1, at0, at1;

  int n_cmp = 0;
  int n_err = 0;

  int m_ph[2]   = '{0, 0};
  int m_lv[2]   = '{0, 0};
  int m_wait[2] = '{0, 0};
  int m_dead[2] = '{0, 0};
  bit m_dir[2]  = '{0, 0};
  bit m_busy[2] = '{0, 0};
  bit m_at[2]   = '{0, 0};

  always #5 clk = ~clk;

  dc_motor_ramp_ctrl #(.CLK_FREQ(1000), .STEP_MS(2), .DEADTIME_MS(4), .MAX_LEVEL(15)) u_dut15 (
    .clk(clk), .rst(rst), .enable(enable), .target_level(target_level), .target_dir(target_dir),
    .estop(estop), .speed_level(speed0), .motor_dir(dir0), .busy(busy0), .at_target(at0)
  );

  dc_motor_ramp_ctrl #(.CLK_FREQ(1000), .STEP_MS(2), .DEADTIME_MS(4), .MAX_LEVEL(10)) u_dut10 (
    .clk(clk), .rst(rst), .enable(enable), .target_level(target_level), .target_dir(target_dir),
    .estop(estop), .speed_level(speed1), .motor_dir(dir1), .busy(busy1), .at_target(at1)
  );

  task automatic start_ramp(input int k, input int ph);
    m_ph[k]   = ph;
    m_wait[k] = STEP_N;
  endtask

  task automatic count_down(input int k, output bit fire);
    m_wait[k] = m_wait[k] - 1;
    fire = (m_wait[k] == 0);
    if (fire) m_wait[k] = STEP_N;
  endtask

  task automatic reverse_at_zero(input int k, input int eff);
    if (DEAD_EN) begin
      m_ph[k]   = P_DEAD;
      m_dead[k] = DEAD_N;
    end else begin
      m_dir[k] = target_dir;
      if (eff > 0) start_ramp(k, P_ACCEL);
      else m_ph[k] = P_IDLE;
    end
  endtask

  task automatic model_step(input int k);
    int mx, eff, lv;
    bit flip, fire;
    mx   = (k == 0) ? 15 : 10;
    eff  = enable ? ((int'(target_level) > mx) ? mx : int'(target_level)) : 0;
    flip = (target_dir != m_dir[k]);
    lv   = m_lv[k];
    fire = 1'b0;
    if (estop) begin
      m_ph[k] = P_ESTOP;
      lv = 0;
    end else begin
      case (m_ph[k])
        P_IDLE, P_HOLD: begin
          if (flip && lv == 0) reverse_at_zero(k, eff);
          else if (flip || eff < lv) start_ramp(k, P_DECEL);
          else if (eff > lv) start_ramp(k, P_ACCEL);
          else if (lv == 0) m_ph[k] = P_IDLE;
        end
        P_ACCEL: begin
          if (flip || eff < lv) begin
            count_down(k, fire);
            m_ph[k] = P_DECEL;
          end else if (eff == lv) begin
            m_ph[k] = P_HOLD;
          end else begin
            count_down(k, fire);
            if (fire) lv = lv + 1;
            if (lv == eff) m_ph[k] = P_HOLD;
          end
        end
        P_DECEL: begin
          if (flip && lv == 0) reverse_at_zero(k, eff);
          else if (!flip && eff > lv) begin
            count_down(k, fire);
            m_ph[k] = P_ACCEL;
          end else if (!flip && eff == lv) begin
            m_ph[k] = P_HOLD;
          end else begin
            count_down(k, fire);
            if (fire) begin
              lv = lv - 1;
              if (flip && lv == 0) reverse_at_zero(k, eff);
              else if (!flip && lv == eff) m_ph[k] = P_HOLD;
            end
          end
        end
        P_DEAD: begin
          m_dead[k] = m_dead[k] - 1;
          if (m_dead[k] == 0) begin
            m_dir[k] = target_dir;
            if (eff > 0) start_ramp(k, P_ACCEL);
            else m_ph[k] = P_IDLE;
          end
        end
        default: if (!enable) m_ph[k] = P_IDLE;
      endcase
    end
    m_lv[k]   = lv;
    m_busy[k] = (m_ph[k] == P_ACCEL) || (m_ph[k] == P_DECEL) || (m_ph[k] == P_DEAD);
    m_at[k]   = ((m_ph[k] == P_IDLE) || (m_ph[k] == P_HOLD)) && (lv == eff) &&
                ((m_dir[k] == target_dir) || (lv == 0));
  endtask

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_ph[k] = P_IDLE; m_lv[k] = 0; m_wait[k] = 0; m_dead[k] = 0;
        m_dir[k] = 1'b0; m_busy[k] = 1'b0; m_at[k] = 1'b0;
      end else begin
        model_step(k);
      end
    end
  end

  function automatic logic [31:0] model_vec(input int k);
    return 32'((m_lv[k] << 3) | (int'(m_dir[k]) << 2) | (int'(m_busy[k]) << 1) | int'(m_at[k]));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one cycle and compare both instances against the model.
  task automatic tick();
    @(negedge clk);
    if (!rst) begin
      check("model_max15", {25'd0, speed0, dir0, busy0, at0}, model_vec(0));
      check("model_max10", {25'd0, speed1, dir1, busy1, at1}, model_vec(1));
    end
  endtask

  task automatic wait_at(input int k, input int budget);
    int n;
    logic a;
    n = 0;
    do begin
      tick();
      n++;
      a = (k == 0) ? at0 : at1;
    end while (a !== 1'b1 && n < budget);
    check("wait_at_target", 32'(a), 1);
  endtask

  initial begin
    int es_left;
    es_left = 0;
    repeat (2) tick();
    check("reset_speed", 32'(speed0), 0);
    check("reset_dir", 32'(dir0), 0);
    check("reset_busy", 32'(busy0), 0);
    check("reset_at", 32'(at0), 0);
    rst = 1'b0;
    tick();
    check("idle_at_target", 32'(at0), 1);

    // Ramp 0 -> 3: one level every two cycles.
    enable = 1'b1; target_level = 4'd3; target_dir = 1'b0;
    repeat (3) tick(); check("ramp_l1", 32'(speed0), 1);
    repeat (2) tick(); check("ramp_l2", 32'(speed0), 2);
    tick();            check("ramp_busy", 32'(busy0), 1); check("ramp_at_lo", 32'(at0), 0);
    tick();            check("ramp_l3", 32'(speed0), 3); check("ramp_busy_done", 32'(busy0), 0);
    check("ramp_at_hi", 32'(at0), 1);

    // Toward 15, retarget to 5 at level 8.
    target_level = 4'd15;
    repeat (11) tick(); check("to15_l8", 32'(speed0), 8);
    target_level = 4'd5;
    repeat (2) tick();  check("retarget_l7", 32'(speed0), 7);
    repeat (4) tick();  check("retarget_l5", 32'(speed0), 5); check("retarget_at", 32'(at0), 1);

    // Hold at 2, then reverse.
    target_level = 4'd2;
    wait_at(0, 40);
    check("hold2", 32'(speed0), 2);
    target_dir = 1'b1;
    repeat (3) tick(); check("rev_l1", 32'(speed0), 1);
    repeat (2) tick(); check("rev_l0", 32'(speed0), 0);
`ifdef DC_RAMP_DEADTIME_EN
    check("rev_dir_dwell", 32'(dir0), 0); check("rev_busy_dwell", 32'(busy0), 1);
    repeat (3) tick(); check("rev_dir_late", 32'(dir0), 0);
    tick();            check("rev_dir_flip", 32'(dir0), 1);
    repeat (4) tick(); check("rev_back_l2", 32'(speed0), 2); check("rev_back_at", 32'(at0), 1);
`else
    check("rev_dir_flip", 32'(dir0), 1);
    repeat (4) tick(); check("rev_back_l2", 32'(speed0), 2); check("rev_back_at", 32'(at0), 1);
`endif

    // Emergency stop at level 5.
    target_level = 4'd5;
    wait_at(0, 40);
    check("pre_estop_l5", 32'(speed0), 5);
    estop = 1'b1;
    tick();
    check("estop_l0", 32'(speed0), 0); check("estop_dir", 32'(dir0), 1);
    check("estop_at", 32'(at0), 0);
    estop = 1'b0;
    repeat (5) tick();
    check("estop_hold_l0", 32'(speed0), 0); check("estop_hold_busy", 32'(busy0), 0);
    enable = 1'b0;
    tick();
    check("estop_exit_at", 32'(at0), 1);

    // Asynchronous reset mid-ACCEL.
    enable = 1'b1; target_level = 4'd15;
    repeat (6) tick();
    check("accel_l2", 32'(speed0), 2); check("accel_busy", 32'(busy0), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_l0", 32'(speed0), 0); check("arst_dir", 32'(dir0), 0);
    check("arst_busy", 32'(busy0), 0); check("arst_at", 32'(at0), 0);
    check("arst_l0_max10", 32'(speed1), 0);
    #1 rst = 1'b0;

    // Clamp: request 15 with MAX_LEVEL 10.
    wait_at(1, 80);
    check("clamp_l10", 32'(speed1), 10); check("clamp_busy", 32'(busy1), 0);
    wait_at(0, 60);
    check("full_l15", 32'(speed0), 15);

    for (int i = 0; i < 2500; i++) begin
      if (es_left > 0) begin
        es_left--;
        if (es_left == 0) estop = 1'b0;
      end else if ($urandom_range(0, 149) == 0) begin
        estop = 1'b1;
        es_left = $urandom_range(1, 4);
      end
      if ($urandom_range(0, 7) == 0) target_level = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 59) == 0) target_dir = ~target_dir;
      rst = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 1'b0;
    estop = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
